wb_regfile: RTL and testbench

//  Architectural integer register file; consumer end of the MEM/WB write-back bus.

---
 rtl/wb_regfile_pkg.sv | 20 ++
 rtl/wb_regfile_read_port.sv | 44 ++++
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file.
package wb_regfile_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_CNT_W    = 64;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic READ_ENABLE   = 1'b1;

   // Where a read port takes its data from this cycle.
   typedef enum logic [1:0] {
      SRC_ZERO   = 2'd0,
      SRC_BYPASS = 2'd1,
      SRC_ARRAY  = 2'd2
   } rd_src_e;

endpackage

// File: rtl/wb_regfile_read_port.sv
// One combinational read port: zero / write-through bypass / array select.
module wb_regfile_read_port
   import wb_regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              rst_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              wb_wreg_i,
   input  logic [ADDR_W-1:0] wb_wd_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic [DATA_W-1:0] array_data_i,
   output logic [DATA_W-1:0] rdata_o
);

   rd_src_e src_d;

   // Pick the data source; earlier conditions dominate, x0 is never bypassed.
   always_comb begin
      src_d = SRC_ARRAY;
      if (rst_i == RST_ENABLE) begin
         src_d = SRC_ZERO;
      end else if (re_i != READ_ENABLE) begin
         src_d = SRC_ZERO;
      end else if (raddr_i == '0) begin
         src_d = SRC_ZERO;
      end else if ((wb_wreg_i == WRITE_ENABLE) && (wb_wd_i == raddr_i)) begin
         src_d = SRC_BYPASS;
      end
   end

   // Drive the selected data onto the port.
   always_comb begin
      rdata_o = '0;
      case (src_d)
         SRC_BYPASS: rdata_o = wb_wdata_i;
         SRC_ARRAY:  rdata_o = array_data_i;
         default:    rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the end of the write-back bus, with
// two bypassed read ports and a committed-write counter.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic              wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [CNT_W-1:0]  commit_cnt
);

   localparam int NUM_PORTS = 2;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [CNT_W-1:0]  commit_cnt_q;
   logic [CNT_W-1:0]  commit_cnt_d;
   logic              commit_en;

   logic              re_vec    [NUM_PORTS];
   logic [ADDR_W-1:0] raddr_vec [NUM_PORTS];
   logic [DATA_W-1:0] rdata_vec [NUM_PORTS];

   // A slot commits only when enabled and aimed at a real register (not x0).
   always_comb begin
      commit_en    = (wb_wreg == WRITE_ENABLE) && (wb_wd != '0);
      commit_cnt_d = commit_en ? (commit_cnt_q + 1'b1) : commit_cnt_q;
   end

   // Array write and commit counter; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         commit_cnt_q <= '0;
      end else begin
         if (commit_en) begin
            regs_q[wb_wd] <= wb_wdata;
         end
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign re_vec[0]    = re1;
   assign re_vec[1]    = re2;
   assign raddr_vec[0] = raddr1;
   assign raddr_vec[1] = raddr2;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
         wb_regfile_read_port #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_port (
            .rst_i        (rst),
            .re_i         (re_vec[gi]),
            .raddr_i      (raddr_vec[gi]),
            .wb_wreg_i    (wb_wreg),
            .wb_wd_i      (wb_wd),
            .wb_wdata_i   (wb_wdata),
            .array_data_i (regs_q[raddr_vec[gi]]),
            .rdata_o      (rdata_vec[gi])
         );
      end
   endgenerate

   assign rdata1     = rdata_vec[0];
   assign rdata2     = rdata_vec[1];
   assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, random traffic
// against a reference model, and a hand-written asynchronous reset sequence.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic [63:0] commit_cnt;

   int n_total;
   int n_pass;

   // Reference state: what each register architecturally holds, and the count.
   logic [31:0] m_regs [32];
   longint unsigned m_cnt;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic [63:0] expc;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .wb_wd      (wb_wd),
      .wb_wreg    (wb_wreg),
      .wb_wdata   (wb_wdata),
      .re1        (re1),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .re2        (re2),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .commit_cnt (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                               input logic [31:0] e1, input logic [31:0] e2, input logic [63:0] ec);
      vec_t v;
      v.wd = wd; v.wreg = wreg; v.wdata = wdata;
      v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
      v.exp1 = e1; v.exp2 = e2; v.expc = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Value a read port must show, straight from the read rules.
   function automatic logic [31:0] m_read(input logic r, input logic [4:0] a);
      if (rst) return 32'h0;
      if (!r) return 32'h0;
      if (a == 5'd0) return 32'h0;
      if (wb_wreg && wb_wd == a) return wb_wdata;
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
   endtask

   task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
      wb_wd = wd; wb_wreg = wreg; wb_wdata = wdata;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
   endtask

   // Take a clock edge and apply the commit rule to the model.
   task automatic edge_step();
      @(posedge clk);
      if (!rst && wb_wreg && wb_wd != 5'd0) begin
         m_regs[wb_wd] = wb_wdata;
         m_cnt++;
      end
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      m_reset();

      vecs[0]  = mk(5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd6, 32'hDEADBEEF, 32'h0, 64'd0);
      vecs[1]  = mk(5'd5, 1'b0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 64'd1);
      vecs[2]  = mk(5'd7, 1'b1, 32'h12345678, 1'b1, 5'd5, 1'b1, 5'd7, 32'hDEADBEEF, 32'h12345678, 64'd1);
      vecs[3]  = mk(5'd0, 1'b0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd5, 32'h12345678, 32'hDEADBEEF, 64'd2);
      vecs[4]  = mk(5'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 64'd2);
      vecs[5]  = mk(5'd0, 1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd7, 32'h0, 32'h12345678, 64'd2);
      vecs[6]  = mk(5'd3, 1'b0, 32'hAAAA5555, 1'b1, 5'd3, 1'b1, 5'd3, 32'h0, 32'h0, 64'd2);
      vecs[7]  = mk(5'd0, 1'b0, 32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 32'h0, 32'h0, 64'd2);
      vecs[8]  = mk(5'd9, 1'b1, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 64'd2);
      vecs[9]  = mk(5'd0, 1'b0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 64'd3);
      vecs[10] = mk(5'd0, 1'b0, 32'h0,        1'b0, 5'd9, 1'b1, 5'd9, 32'h0, 32'hCAFEF00D, 64'd3);
      vecs[11] = mk(5'd9, 1'b1, 32'h11112222, 1'b1, 5'd9, 1'b0, 5'd9, 32'h11112222, 32'h0, 64'd3);
      vecs[12] = mk(5'd0, 1'b0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd5, 32'h11112222, 32'hDEADBEEF, 64'd4);

      // Reset state, with reads enabled so only reset can force zero.
      rst = 1'b1;
      drive(5'd4, 1'b1, 32'h0BADF00D, 1'b1, 5'd4, 1'b1, 5'd4);
      #1;
      chk("reset_rdata1", {32'h0, rdata1}, 64'h0);
      chk("reset_rdata2", {32'h0, rdata2}, 64'h0);
      chk("reset_cnt", commit_cnt, 64'd0);
      edge_step();
      edge_step();
      rst = 1'b0;
      drive(5'd0, 1'b0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd1);
      #1;
      chk("post_reset_x4", {32'h0, rdata1}, 64'h0);
      edge_step();

      // Directed vectors: expectations sampled before the edge of each row.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
         #1;
         chk($sformatf("vec%0d_rdata1", i), {32'h0, rdata1}, {32'h0, vecs[i].exp1});
         chk($sformatf("vec%0d_rdata2", i), {32'h0, rdata2}, {32'h0, vecs[i].exp2});
         chk($sformatf("vec%0d_cnt", i), commit_cnt, vecs[i].expc);
         $display("vec %0d wd=%0d wreg=%b wdata=%h r1=%0d:%h r2=%0d:%h cnt=%0d",
                  i, wb_wd, wb_wreg, wb_wdata, raddr1, rdata1, raddr2, rdata2, commit_cnt);
         edge_step();
      end

      // Random traffic against the model; reads often aimed at the write target.
      for (int n = 0; n < 300; n++) begin
         logic [4:0] wd, a1, a2;
         wd = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 2) == 0) ? wd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? wd : 5'($urandom_range(0, 31));
         drive(wd, 1'($urandom_range(0, 3) != 0), $urandom,
               1'($urandom_range(0, 4) != 0), a1, 1'($urandom_range(0, 4) != 0), a2);
         #1;
         chk($sformatf("rnd%0d_rdata1", n), {32'h0, rdata1}, {32'h0, m_read(re1, raddr1)});
         chk($sformatf("rnd%0d_rdata2", n), {32'h0, rdata2}, {32'h0, m_read(re2, raddr2)});
         chk($sformatf("rnd%0d_cnt", n), commit_cnt, m_cnt);
         $display("rnd %0d wd=%0d wreg=%b r1=%0d:%h r2=%0d:%h cnt=%0d",
                  n, wb_wd, wb_wreg, raddr1, rdata1, raddr2, rdata2, commit_cnt);
         edge_step();
      end

      // Asynchronous reset mid-run: known content in x12, write to x13 in flight.
      drive(5'd12, 1'b1, 32'h5A5A0001, 1'b0, 5'd0, 1'b0, 5'd0);
      edge_step();
      drive(5'd13, 1'b1, 32'h77778888, 1'b1, 5'd13, 1'b1, 5'd12);
      #1;
      chk("pre_rst_bypass", {32'h0, rdata1}, 64'h77778888);
      chk("pre_rst_x12", {32'h0, rdata2}, 64'h5A5A0001);
      rst = 1'b1;
      #1;
      chk("async_rst_rdata1", {32'h0, rdata1}, 64'h0);
      chk("async_rst_rdata2", {32'h0, rdata2}, 64'h0);
      chk("async_rst_cnt", commit_cnt, 64'd0);
      m_reset();
      edge_step();
      rst = 1'b0;
      drive(5'd0, 1'b0, 32'h0, 1'b1, 5'd13, 1'b1, 5'd12);
      #1;
      chk("rst_lost_write_x13", {32'h0, rdata1}, 64'h0);
      chk("rst_cleared_x12", {32'h0, rdata2}, 64'h0);
      chk("rst_cnt_held", commit_cnt, 64'd0);
      drive(5'd31, 1'b1, 32'h00000031, 1'b0, 5'd0, 1'b0, 5'd0);
      edge_step();
      drive(5'd0, 1'b0, 32'h0, 1'b1, 5'd31, 1'b0, 5'd0);
      #1;
      chk("after_rst_x31", {32'h0, rdata1}, 64'h31);
      chk("after_rst_cnt", commit_cnt, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
